// File: rtl/mmio_uart_tx_if.sv
// Data-memory port shared by mmio_uart_tx and bram_sdp.
//   write_enable / write_mask / addr_write / data_in : store side (one cycle per store)
//   read_enable / addr_read                          : load side (one cycle per load)
//   data_out                                         : registered load data, one-cycle latency
// master drives the requests; slave (the responder) drives data_out.
interface mmio_uart_tx_if;
    logic        write_enable;
    logic        read_enable;
    logic [3:0]  write_mask;
    logic [31:0] addr_write;
    logic [31:0] addr_read;
    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (
        output write_enable, read_enable, write_mask, addr_write, addr_read, data_in,
        input  data_out
    );

    modport slave (
        input  write_enable, read_enable, write_mask, addr_write, addr_read, data_in,
        output data_out
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory port.
// Stores to TXDATA push bytes into a TX FIFO; a serializer shifts them out LSB first.
// Loads of STATUS return {count[7:4], overflow[3], empty[2], full[1], busy[0]}.
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : store/load port (slave side), registered data_out
//   tx    : serial line, idle high
// Register window (16 bytes at BASE_ADDR): +0 TXDATA (W), +4 STATUS (R, bit3 W1C), +8/+C zero.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_4000,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic          clock,
    input  logic          reset,
    mmio_uart_tx_if.slave bus,
    output logic          tx
);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // Bus decode
    logic       w_wr_hit;
    logic       w_rd_hit;
    logic [1:0] w_wr_off;
    logic [1:0] w_rd_off;
    logic       w_push_req;
    logic       w_push;
    logic       w_ovf_clr;

    assign w_wr_hit   = bus.write_enable && (bus.addr_write[31:4] == BASE_ADDR[31:4]);
    assign w_rd_hit   = bus.read_enable && (bus.addr_read[31:4] == BASE_ADDR[31:4]);
    assign w_wr_off   = bus.addr_write[3:2];
    assign w_rd_off   = bus.addr_read[3:2];
    assign w_push_req = w_wr_hit && (w_wr_off == 2'd0) && bus.write_mask[0];
    assign w_ovf_clr  = w_wr_hit && (w_wr_off == 2'd1) && bus.write_mask[0] && bus.data_in[3];

    // Only the low byte lane and word offset matter to this block
    logic w_unused;
    assign w_unused = ^{bus.write_mask[3:1], bus.data_in[31:8], bus.addr_write[1:0],
                        bus.addr_read[1:0]};

    // FIFO
    logic [7:0]      r_fifo [FIFO_DEPTH];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;
    logic            r_overflow;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;

    assign w_full  = (r_count == CntFull);
    assign w_empty = (r_count == '0);
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands
    assign w_push  = w_push_req && (!w_full || w_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CntW'(1);
            end
            if (w_push_req && !w_push) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Storage needs no reset: pointers define what is valid
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.data_in[7:0];
        end
    end

    // Serializer
    state_e           r_state;
    state_e           w_state_next;
    logic [BaudW-1:0] r_baud;
    logic [BaudW-1:0] w_baud_next;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_idx_next;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_next;
    logic             r_tx;
    logic             w_tx_next;
    logic             w_baud_done;

    assign w_baud_done = (r_baud == BaudLast);

    always_comb begin
        w_state_next   = r_state;
        w_baud_next    = r_baud;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_tx_next      = r_tx;
        w_pop          = 1'b0;
        case (r_state)
            StIdle: begin
                w_tx_next = 1'b1;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = r_fifo[r_rd_ptr];
                    w_baud_next  = '0;
                    w_tx_next    = 1'b0;
                    w_state_next = StStart;
                end
            end
            StStart: begin
                if (w_baud_done) begin
                    w_baud_next    = '0;
                    w_bit_idx_next = 3'd0;
                    w_tx_next      = r_shift[0];
                    w_state_next   = StData;
                end else begin
                    w_baud_next = r_baud + BaudW'(1);
                end
            end
            StData: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_tx_next    = 1'b1;
                        w_state_next = StStop;
                    end else begin
                        // Next bit is shift[1] before the shift takes effect
                        w_shift_next   = {1'b0, r_shift[7:1]};
                        w_tx_next      = r_shift[1];
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud + BaudW'(1);
                end
            end
            StStop: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_tx_next    = 1'b1;
                    w_state_next = StIdle;
                end else begin
                    w_baud_next = r_baud + BaudW'(1);
                end
            end
            default: begin
                w_tx_next    = 1'b1;
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= StIdle;
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
        end
    end

    assign tx = r_tx;

    // Status and registered load data
    logic [3:0]  w_count_disp;
    logic [31:0] w_status;
    logic [31:0] r_data_out;

    assign w_count_disp = (32'(r_count) > 32'd15) ? 4'hF : 4'(r_count);
    assign w_status     = {24'd0, w_count_disp, r_overflow, w_empty, w_full,
                           (r_state != StIdle)};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_data_out <= '0;
        end else if (w_rd_hit) begin
            r_data_out <= (w_rd_off == 2'd1) ? w_status : 32'd0;
        end
    end

    assign bus.data_out = r_data_out;
endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE  = 32'h0000_4000;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic tx;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus),
        .tx   (tx)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: byte queue plus the edge number at which the current frame started.
    logic [7:0]  m_q [$];
    logic        m_ovf    = 1'b0;
    logic [31:0] m_dout   = 32'd0;
    logic        m_active = 1'b0;
    int          m_start  = 0;
    logic [7:0]  m_byte   = 8'd0;
    int          cyc      = 0;

    function automatic logic m_busy_after(input int e);
        return m_active && ((e - m_start) < 10 * CPB);
    endfunction

    function automatic logic model_idle();
        return !m_busy_after(cyc) && (m_q.size() == 0);
    endfunction

    // Frame = start(0), 8 data bits LSB first, stop(1); each CPB edges long
    function automatic logic model_tx();
        int d;
        if (!m_busy_after(cyc)) return 1'b1;
        d = (cyc - m_start) / CPB;
        if (d == 0) return 1'b0;
        if (d == 9) return 1'b1;
        return m_byte[d-1];
    endfunction

    task automatic model_step();
        logic        busy_pre;
        logic        pop;
        logic        accept;
        logic [31:0] status;
        logic        wr_hit;
        logic        rd_hit;
        cyc++;
        if (reset) begin
            m_q.delete();
            m_ovf    = 1'b0;
            m_dout   = 32'd0;
            m_active = 1'b0;
            return;
        end
        busy_pre  = m_busy_after(cyc - 1);
        status    = 32'd0;
        status[0] = busy_pre;
        status[1] = (m_q.size() == DEPTH);
        status[2] = (m_q.size() == 0);
        status[3] = m_ovf;
        status[7:4] = (m_q.size() > 15) ? 4'hF : 4'(m_q.size());
        wr_hit = bus.write_enable && (bus.addr_write[31:4] == BASE[31:4]);
        rd_hit = bus.read_enable && (bus.addr_read[31:4] == BASE[31:4]);
        if (rd_hit) m_dout = (bus.addr_read[3:2] == 2'd1) ? status : 32'd0;
        pop    = !busy_pre && (m_q.size() > 0);
        accept = 1'b0;
        if (wr_hit && bus.addr_write[3:2] == 2'd0 && bus.write_mask[0]) begin
            if (m_q.size() < DEPTH || pop) accept = 1'b1;
            else m_ovf = 1'b1;
        end
        if (wr_hit && bus.addr_write[3:2] == 2'd1 && bus.write_mask[0] && bus.data_in[3])
            m_ovf = 1'b0;
        if (pop) begin
            m_byte   = m_q.pop_front();
            m_start  = cyc;
            m_active = 1'b1;
        end
        if (accept) m_q.push_back(bus.data_in[7:0]);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        #1;
        chk("tx", {31'd0, tx}, {31'd0, model_tx()});
        chk("data_out", bus.data_out, m_dout);
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        bus.write_enable = 1'b1;
        bus.addr_write   = a;
        bus.write_mask   = m;
        bus.data_in      = d;
    endtask

    task automatic rd(input logic [31:0] a);
        bus.read_enable = 1'b1;
        bus.addr_read   = a;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!model_idle() && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_wait: got %0d cycles, expected under 2000", n);
        end
        rd(BASE + 32'h4);
        step();
        chk("idle_status", bus.data_out, 32'h4);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] lo;
        lo = {30'd0, 2'($urandom)};
        case ($urandom_range(0, 5))
            0: return BASE + lo;
            1: return BASE + 32'h4 + lo;
            2: return BASE + 32'h8 + lo;
            3: return BASE + 32'hC + lo;
            4: return BASE + 32'h10 + lo;
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic        we;
        logic [31:0] waddr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic        re;
        logic [31:0] raddr;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t        vecs [10];
    logic        txs  [200];
    logic        t1_tx [42];
    logic [31:0] t1_do [42];
    logic [9:0]  frame;
    int          s1;
    int          s2;
    logic [7:0]  dec;

    initial begin
        // Single-cycle register accesses from idle; data_out after the edge
        vecs[0] = '{1'b0, 32'h0,          4'h0, 32'h0,    1'b1, BASE + 32'h4,  32'h4};
        vecs[1] = '{1'b0, 32'h0,          4'h0, 32'h0,    1'b1, BASE,          32'h0};
        vecs[2] = '{1'b1, BASE,           4'h2, 32'h5A00, 1'b1, BASE + 32'h4,  32'h4};
        vecs[3] = '{1'b1, BASE + 32'h10,  4'h1, 32'h77,   1'b1, BASE + 32'h4,  32'h4};
        vecs[4] = '{1'b1, BASE + 32'h8,   4'hF, 32'hFF,   1'b1, BASE + 32'h8,  32'h0};
        vecs[5] = '{1'b1, BASE,           4'h0, 32'h33,   1'b1, BASE + 32'h4,  32'h4};
        vecs[6] = '{1'b0, 32'h0,          4'h0, 32'h0,    1'b0, BASE + 32'h4,  32'h4};
        vecs[7] = '{1'b0, 32'h0,          4'h0, 32'h0,    1'b1, BASE + 32'h14, 32'h4};
        vecs[8] = '{1'b0, 32'h0,          4'h0, 32'h0,    1'b1, BASE + 32'hC,  32'h0};
        vecs[9] = '{1'b1, BASE + 32'h4,   4'h1, 32'h8,    1'b1, BASE + 32'h5,  32'h4};

        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
        bus.write_mask   = 4'h0;
        bus.addr_write   = 32'h0;
        bus.addr_read    = 32'h0;
        bus.data_in      = 32'h0;

        reset = 1'b1;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b0;
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_data_out", bus.data_out, 32'd0);

        // Register map, miss handling, read hold
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].we) wr(vecs[i].waddr, vecs[i].mask, vecs[i].wdata);
            if (vecs[i].re) rd(vecs[i].raddr);
            step();
            chk($sformatf("vec%0d", i), bus.data_out, vecs[i].exp_dout);
        end
        for (int i = 0; i < 100; i++) begin
            step();
            chk("idle_line", {31'd0, tx}, 32'd1);
        end

        // Single frame of 8'hA5
        frame = {1'b1, 8'hA5, 1'b0};
        wr(BASE, 4'h1, 32'hA5);
        step();
        for (int k = 0; k < 42; k++) begin
            rd(BASE + 32'h4);
            step();
            t1_tx[k] = tx;
            t1_do[k] = bus.data_out;
        end
        for (int k = 0; k < 40; k++) chk($sformatf("a5_bit%0d", k), {31'd0, t1_tx[k]},
                                         {31'd0, frame[k/CPB]});
        chk("a5_after", {31'd0, t1_tx[40]}, 32'd1);
        chk("a5_queued", t1_do[0], 32'h10);
        for (int k = 1; k < 41; k++) chk("a5_busy", t1_do[k], 32'h5);
        chk("a5_done", t1_do[41], 32'h4);

        // Fill to full, overflow, W1C
        for (int i = 1; i <= 9; i++) begin
            wr(BASE, 4'h1, i);
            step();
            if (i == 2) chk("pop_next_cycle", {31'd0, tx}, 32'd0);
        end
        wr(BASE, 4'h1, 32'h0A);
        step();
        rd(BASE + 32'h4);
        step();
        chk("ovf_status", bus.data_out, 32'h8B);
        wr(BASE + 32'h4, 4'h1, 32'h8);
        step();
        rd(BASE + 32'h4);
        step();
        chk("ovf_clear", bus.data_out, 32'h83);
        wait_idle();

        // Back-to-back frames
        wr(BASE, 4'h1, 32'h55);
        step();
        wr(BASE, 4'h1, 32'h0F);
        for (int k = 0; k < 200; k++) begin
            step();
            txs[k] = tx;
        end
        s1 = -1;
        s2 = -1;
        for (int k = 0; k < 200; k++) if (s1 < 0 && !txs[k]) s1 = k;
        if (s1 >= 0) for (int k = s1 + 40; k < 200; k++) if (s2 < 0 && !txs[k]) s2 = k;
        if (s1 < 0 || s2 < 0 || s2 + 36 >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL b2b_start: got s1=%0d s2=%0d, expected two start bits", s1, s2);
        end else begin
            chk("b2b_gap", s2 - s1, 41);
            for (int i = 0; i < 8; i++) dec[i] = txs[s1 + CPB * (i + 1)];
            chk("b2b_byte0", {24'd0, dec}, 32'h55);
            for (int i = 0; i < 8; i++) dec[i] = txs[s2 + CPB * (i + 1)];
            chk("b2b_byte1", {24'd0, dec}, 32'h0F);
            chk("b2b_stop1", {31'd0, txs[s2 + 36]}, 32'd1);
        end
        wait_idle();

        // Reset during DATA bit 3 with a second byte still queued
        wr(BASE, 4'h1, 32'hFF);
        step();
        wr(BASE, 4'h1, 32'hFF);
        step();
        chk("ff_start", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 17; i++) step();
        reset = 1'b1;
        step();
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_data_out", bus.data_out, 32'd0);
        reset = 1'b0;
        rd(BASE + 32'h4);
        step();
        chk("rst_status", bus.data_out, 32'h4);
        for (int i = 0; i < 100; i++) begin
            step();
            chk("no_frame", {31'd0, tx}, 32'd1);
        end

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, (i < 1500) ? 1 : 7) == 0)
                wr(rand_addr(), 4'($urandom), $urandom);
            if ($urandom_range(0, 1) == 0) rd(rand_addr());
            reset = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that acts as the responder on the processor's data-memory port.
- Sits beside bram_sdp on the same write/read bus, with identical signalling: enable + word address + byte mask, and registered read data.
- Processor stores push bytes into a TX FIFO, and a serializer shifts them out as 8N1.
- Processor loads read a status word.

Parameters:
- BASE_ADDR, 32'h0000_4000, byte address of the 16-byte register window; must be 16-byte aligned.
- CLKS_PER_BIT, 868, clock cycles per UART bit; must be ≥2.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, ≥2.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- write_enable  in  1  store strobe, one cycle per store.
- read_enable  in  1  load strobe, one cycle per load.
- write_mask  in  4  byte-lane enables for the store.
- addr_write  in  32  store byte address.
- addr_read  in  32  load byte address.
- data_in  in  32  store data.
- data_out  out  32  registered load data.
- tx  out  1  UART serial line, idle high.

Behaviour:
- Clock and reset: one clock (clock). Reset is synchronous and active-high (reset).
- Reset values: tx=1, data_out=0, FIFO empty (count=0, pointers 0), overflow flag=0, serializer in IDLE, baud counter=0, bit index=0.
- Address decode: an access hits when addr[31:4]==BASE_ADDR[31:4]. Offset = addr[3:2]. Accesses that miss the window are ignored: no state change, data_out holds.
- Register map:
  - Offset 0, TXDATA, write-only. A write with write_mask[0]=1 pushes data_in[7:0]. Other lanes are ignored. A write with mask[0]=0 has no effect. Reads return 0.
  - Offset 1, STATUS:
    - bit0 busy: serializer not IDLE.
    - bit1 full.
    - bit2 empty.
    - bit3 overflow (sticky).
    - bits[7:4] entry count, saturating display width 4.
    - Other bits 0.
    - Write with mask[0]=1 and data_in[3]=1 clears overflow (W1C). Other bits are read-only.
  - Offsets 2 and 3: reads return 0, writes are ignored.
- Read timing:
  - One-cycle latency, matching bram_sdp. When read_enable=1 and the address hits, data_out is loaded on that edge with the selected register value sampled before that edge's updates.
  - When read_enable=0, data_out holds its previous value.
  - A read hit outside offsets 0/1 loads 0.
- Push rules:
  - Push accepted if FIFO not full, or if a pop occurs on the same edge. In the second case the count is unchanged.
  - A push when full with no simultaneous pop is dropped and sets overflow.
  - Overflow set and W1C clear cannot collide: they come from separate stores on different cycles.
- Simultaneous read and write on the same edge is permitted. The read returns pre-edge state.
- Serializer FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO non-empty, pop the head into an 8-bit shift register, clear the baud counter, and go to START. The pop happens on this edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] (LSB first) for CLKS_PER_BIT cycles per bit. After each bit, shift right and increment the index. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Back-to-back frames: IDLE spends exactly one cycle (tx=1) before popping the next byte. Frame length is therefore 10·CLKS_PER_BIT+1 cycles, measured start-edge to start-edge.
- tx is registered. It changes on the edge that enters each state or bit.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps on bit advance.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- Reset mid-frame: aborts immediately. tx returns to 1 on the reset edge, FIFO contents are discarded, and no partial frame resumes.
- Status busy=1 from the pop edge until the edge returning to IDLE.

Test Plan:
1. CLKS_PER_BIT=4. Store 32'hA5 to BASE+0, mask 4'b0001 → after the write edge, tx frame = 0 (4 cyc), bits 1,0,1,0,0,1,0,1 (4 cyc each), 1 (4 cyc). Total 40 cycles. busy=1 throughout the frame.
2. Load BASE+4 while idle, read_enable for 1 cycle → data_out=32'h0000_0004 on the next edge. Holds after read_enable drops.
3. Store 9 bytes 8'h01..8'h09 on consecutive cycles with the serializer idle → first byte popped on the following cycle. The 9th store is accepted only if it coincides with a pop; otherwise overflow=1. Then store 32'h8 to BASE+4 → overflow=0.
4. Two bytes 8'h55, 8'h0F queued → second start bit begins exactly 41 cycles after the first start bit. Serial data matches LSB-first order.
5. Assert reset during DATA bit 3 of byte 8'hFF → tx=1 on the reset edge. STATUS read afterwards = 32'h0000_0004. No further frames.
6. Store to BASE+0 with mask 4'b0010, and a store to BASE+32'h10 (miss) → FIFO unchanged (empty=1). tx stays 1 for 100 cycles.
